lab8_soc_pio_gen2: RTL and testbench
====================================

// Module: lab8_soc_pio_gen2
// PURPOSE
//  Parametrised Avalon-MM parallel I/O peripheral for the lab8 SoC; next generation of the fixed 8-bit output PIOs.
//  Provides an output register with atomic set/clear, a synchronised input port, per-bit edge capture and a maskable IRQ.
//  Sits on the NIOS II data master; one instance replaces separate status/control PIOs (e.g. game-state flags plus button inputs).
// PARAMETERS
//  DATA_WIDTH   8   bits per port, 1..32; writedata above DATA_WIDTH ignored, readdata zero-extended
//  OUT_RESET    0   reset value of OUT register (DATA_WIDTH bits)
//  EDGE_TYPE    0   capture on 0=rising, 1=falling, 2=any edge
// PORTS
//  clk        in   1           system clock
//  reset_n    in   1           reset: synchronous and active-low
//  address    in   3           word address of register
//  chipselect in   1           slave select
//  write_n    in   1           active-low write strobe
//  writedata  in   32          write data
//  readdata   out  32          read data, zero wait states
//  in_port    in   DATA_WIDTH  asynchronous external inputs
//  out_port   out  DATA_WIDTH  external outputs = OUT register
//  irq        out  1           level interrupt to CPU
// BEHAVIOUR
//  Write = chipselect & ~write_n at posedge clk. Reads combinational: readdata valid same cycle as address, no side effects.
//  Map: 0 OUT (RW); 1 IN (RO, synchronised in_port); 2 IRQ_MASK (RW); 3 EDGE_CAP (R, write-1-to-clear);
//       4 OUTSET (W, OUT |= wd; reads 0); 5 OUTCLR (W, OUT &= ~wd; reads 0); 6,7 reserved: read 0, writes ignored.
//  Reset (reset_n low at posedge): OUT=OUT_RESET, IRQ_MASK=0, EDGE_CAP=0, sync stages=0; irq=0 next cycle.
//  Synchroniser: in_port -> s1 -> s2 (2 flops); s3 = s2 delayed one cycle for edge detect.
//  Latency: in_port change before edge k -> IN read reflects it after edge k+1; EDGE_CAP bit set at edge k+2.
//  Edge detect per bit: rise = s2&~s3; fall = ~s2&s3; any = s2^s3; select per EDGE_TYPE.
//  EDGE_CAP[i] sticky: set on detected edge; cleared only by write 1 to addr 3 or reset.
//  Same-cycle edge and W1C on same bit: set wins (bit stays 1); other bits clear normally.
//  After reset deassertion s3=0: an input already high gives one rising edge (capture) 3 cycles after reset exit — intended.
//  irq = |(EDGE_CAP & IRQ_MASK), registered (1 cycle after the contributing register update).
//  OUT updated at the write edge; out_port changes the same edge (no added latency). OUTSET/OUTCLR single-cycle, no RMW hazard.
//  Reset mid-operation: all state reinitialised regardless of pending write in same cycle (reset has priority).
//  No unused-address aliasing: address decoded on full 3 bits.
// TESTING
//  Reset: hold reset_n low 2 cycles with OUT_RESET=8'hA5 -> out_port=8'hA5, read addr2/3 = 0, irq=0.
//  Write addr0 32'hFFFF_FF3C (DATA_WIDTH=8) -> out_port=8'h3C, readdata=32'h0000_003C.
//  OUT=8'h3C; write addr4 8'h81 -> 8'hBD; then addr5 8'h0C -> 8'hB1; reads of addr4/5 return 0.
//  EDGE_TYPE=0, mask=8'h01, raise in_port[0] -> IN bit visible after 2 edges, EDGE_CAP=8'h01 at 3rd, irq=1 one cycle later; W1C 8'h01 -> irq=0.
//  EDGE_TYPE=0: raise in_port[3] exactly 2 cycles before W1C write of 8'h08 -> EDGE_CAP[3] remains 1.
//  Pulse in_port[1] high 1 cycle with mask 0 -> EDGE_CAP=8'h02, irq stays 0; set mask 8'h02 -> irq=1 one cycle after.

Source files
------------

// File: rtl/lab8_soc_pio_gen2.sv
`default_nettype none
// ============================================================================
//  Module      : lab8_soc_pio_gen2
//  Description : Avalon-MM parallel I/O peripheral. Provides an output
//                register with atomic set/clear, a two-flop synchronised
//                input port, per-bit sticky edge capture and a maskable,
//                registered level interrupt.
//  Ports       : clk, reset_n      - clock, synchronous active-low reset
//                address[2:0]      - register word address
//                chipselect        - slave select
//                write_n           - active-low write strobe
//                writedata[31:0]   - write data (bits above DATA_WIDTH ignored)
//                readdata[31:0]    - combinational read data, zero-extended
//                in_port           - asynchronous external inputs
//                out_port          - OUT register
//                irq               - level interrupt
//  Register map: 0 OUT (RW)      1 IN (RO)      2 IRQ_MASK (RW)
//                3 EDGE_CAP (R, W1C)  4 OUTSET (W)  5 OUTCLR (W)  6,7 reserved
//  Revision    : 1.0 - initial release
// ============================================================================
module lab8_soc_pio_gen2 #(
  parameter int                    DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] OUT_RESET  = '0,
  parameter int                    EDGE_TYPE  = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic                  irq
);

  localparam logic [2:0] c_ADDR_OUT    = 3'd0;
  localparam logic [2:0] c_ADDR_IN     = 3'd1;
  localparam logic [2:0] c_ADDR_MASK   = 3'd2;
  localparam logic [2:0] c_ADDR_EDGE   = 3'd3;
  localparam logic [2:0] c_ADDR_OUTSET = 3'd4;
  localparam logic [2:0] c_ADDR_OUTCLR = 3'd5;

  logic [DATA_WIDTH-1:0] r_out;
  logic [DATA_WIDTH-1:0] r_mask;
  logic [DATA_WIDTH-1:0] r_cap;
  logic [DATA_WIDTH-1:0] r_s1;
  logic [DATA_WIDTH-1:0] r_s2;
  logic [DATA_WIDTH-1:0] r_s3;
  logic                  r_irq;

  logic                  w_wr;
  logic [DATA_WIDTH-1:0] w_wd;
  logic [DATA_WIDTH-1:0] w_edge;
  logic [DATA_WIDTH-1:0] w_clr;
  logic [DATA_WIDTH-1:0] w_rd;

  assign w_wr = chipselect & ~write_n;
  assign w_wd = writedata[DATA_WIDTH-1:0];

  // Upper write-data bits are architecturally ignored.
  generate
    if (DATA_WIDTH < 32) begin : g_wd_hi
      logic w_unused_wdata_hi;
      assign w_unused_wdata_hi = ^writedata[31:DATA_WIDTH];
    end
  endgenerate

  // Edge detection on the synchronised (s2) and one-cycle-delayed (s3) input.
  generate
    if (EDGE_TYPE == 0) begin : g_edge_rise
      assign w_edge = r_s2 & ~r_s3;
    end else if (EDGE_TYPE == 1) begin : g_edge_fall
      assign w_edge = ~r_s2 & r_s3;
    end else begin : g_edge_any
      assign w_edge = r_s2 ^ r_s3;
    end
  endgenerate

  // Write-1-to-clear mask for EDGE_CAP; a new edge in the same cycle wins.
  assign w_clr = (w_wr && address == c_ADDR_EDGE) ? w_wd : '0;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_out  <= OUT_RESET;
      r_mask <= '0;
      r_cap  <= '0;
      r_s1   <= '0;
      r_s2   <= '0;
      r_s3   <= '0;
      r_irq  <= 1'b0;
    end else begin
      r_s1  <= in_port;
      r_s2  <= r_s1;
      r_s3  <= r_s2;
      r_cap <= (r_cap & ~w_clr) | w_edge;
      r_irq <= |(r_cap & r_mask);
      if (w_wr) begin
        case (address)
          c_ADDR_OUT:    r_out  <= w_wd;
          c_ADDR_MASK:   r_mask <= w_wd;
          c_ADDR_OUTSET: r_out  <= r_out | w_wd;
          c_ADDR_OUTCLR: r_out  <= r_out & ~w_wd;
          default:       ;
        endcase
      end
    end
  end

  always_comb begin
    w_rd = '0;
    case (address)
      c_ADDR_OUT:  w_rd = r_out;
      c_ADDR_IN:   w_rd = r_s2;
      c_ADDR_MASK: w_rd = r_mask;
      c_ADDR_EDGE: w_rd = r_cap;
      default:     w_rd = '0;
    endcase
  end

  always_comb begin
    readdata                 = '0;
    readdata[DATA_WIDTH-1:0] = w_rd;
  end

  assign out_port = r_out;
  assign irq      = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_lab8_soc_pio_gen2.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lab8_soc_pio_gen2
//  Description : Self-checking bench for lab8_soc_pio_gen2 (8-bit, OUT_RESET
//                8'hA5, rising-edge capture). Register table, hand-written
//                timing sequences and a randomized run against a
//                history-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lab8_soc_pio_gen2;
  localparam int DW = 8;
  localparam logic [DW-1:0] RST_OUT = 8'hA5;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [2:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic [DW-1:0] in_port;
  logic [DW-1:0] out_port;
  logic          irq;

  always #5 clk = ~clk;

  lab8_soc_pio_gen2 #(.DATA_WIDTH(DW), .OUT_RESET(RST_OUT), .EDGE_TYPE(0)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .out_port(out_port), .irq(irq)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: register contents plus a full history of in_port as
  // sampled at each clock edge. Synchroniser behaviour follows from indexing
  // that history (IN = sample one edge back, edges from samples 2 and 3 back).
  logic [DW-1:0] m_out, m_mask, m_cap;
  logic          m_irq;
  logic [DW-1:0] samp_arr [0:4095];
  int            cyc      = 0;
  int            rst_edge = -100;

  function automatic logic [DW-1:0] sampv(int j);
    if (j <= rst_edge || j < 0) return '0;
    return samp_arr[j];
  endfunction

  function automatic logic [31:0] rd_exp(logic [2:0] a);
    logic [31:0] r;
    r = '0;
    case (a)
      3'd0: r[DW-1:0] = m_out;
      3'd1: r[DW-1:0] = sampv(cyc - 1);
      3'd2: r[DW-1:0] = m_mask;
      3'd3: r[DW-1:0] = m_cap;
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock edge: predict the post-edge state from the current inputs,
  // let the edge happen, then commit the prediction.
  task automatic tick();
    logic [DW-1:0] n_out, n_mask, n_cap, wd, cur, prev;
    logic          n_irq;
    bit            wr;
    int            k;
    k = cyc + 1;
    samp_arr[k] = in_port;
    if (!reset_n) begin
      n_out = RST_OUT; n_mask = '0; n_cap = '0; n_irq = 1'b0;
    end else begin
      wr    = chipselect && !write_n;
      wd    = writedata[DW-1:0];
      cur   = sampv(k - 2);
      prev  = sampv(k - 3);
      n_irq = |(m_cap & m_mask);
      n_out = m_out; n_mask = m_mask; n_cap = m_cap;
      if (wr) begin
        case (address)
          3'd0: n_out  = wd;
          3'd2: n_mask = wd;
          3'd3: n_cap  = m_cap & ~wd;
          3'd4: n_out  = m_out | wd;
          3'd5: n_out  = m_out & ~wd;
          default: ;
        endcase
      end
      n_cap = n_cap | (cur & ~prev);
    end
    @(posedge clk);
    #1;
    cyc = k;
    if (!reset_n) rst_edge = k;
    m_out = n_out; m_mask = n_mask; m_cap = n_cap; m_irq = n_irq;
  endtask

  task automatic idle();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic wr(logic [2:0] a, logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    tick();
    idle();
  endtask

  task automatic rd(string name, logic [2:0] a, logic [31:0] exp);
    address = a;
    #1;
    check(name, readdata, exp);
  endtask

  typedef struct {
    logic [2:0]    waddr;
    logic [31:0]   wdata;
    logic [2:0]    raddr;
    logic [DW-1:0] exp_out;
    logic [31:0]   exp_rd;
  } vec_t;

  vec_t tbl [10];

  initial begin
    tbl[0] = '{3'd0, 32'hFFFF_FF3C, 3'd0, 8'h3C, 32'h0000_003C};
    tbl[1] = '{3'd4, 32'h0000_0081, 3'd4, 8'hBD, 32'h0};
    tbl[2] = '{3'd5, 32'h0000_000C, 3'd5, 8'hB1, 32'h0};
    tbl[3] = '{3'd6, 32'hFFFF_FFFF, 3'd6, 8'hB1, 32'h0};
    tbl[4] = '{3'd7, 32'hFFFF_FFFF, 3'd7, 8'hB1, 32'h0};
    tbl[5] = '{3'd1, 32'hFFFF_FFFF, 3'd0, 8'hB1, 32'h0000_00B1};
    tbl[6] = '{3'd2, 32'hFFFF_FF81, 3'd2, 8'hB1, 32'h0000_0081};
    tbl[7] = '{3'd4, 32'hFFFF_FF00, 3'd0, 8'hB1, 32'h0000_00B1};
    tbl[8] = '{3'd5, 32'hFFFF_FFFF, 3'd0, 8'h00, 32'h0};
    tbl[9] = '{3'd2, 32'h0000_0000, 3'd2, 8'h00, 32'h0};

    reset_n = 1'b0; chipselect = 1'b1; write_n = 1'b0; address = 3'd0;
    writedata = 32'h0000_0012; in_port = '0;
    // Reset held two cycles with a pending write: reset has priority.
    tick(); tick();
    idle();
    check("rst_out_port", {24'h0, out_port}, 32'h0000_00A5);
    check("rst_irq", {31'h0, irq}, 32'h0);
    rd("rst_mask", 3'd2, 32'h0);
    rd("rst_edgecap", 3'd3, 32'h0);
    rd("rst_out_rd", 3'd0, 32'h0000_00A5);
    reset_n = 1'b1;
    tick(); tick(); tick();

    // Register table.
    for (int i = 0; i < 10; i++) begin
      wr(tbl[i].waddr, tbl[i].wdata);
      check($sformatf("tbl%0d_out", i), {24'h0, out_port}, {24'h0, tbl[i].exp_out});
      rd($sformatf("tbl%0d_rd", i), tbl[i].raddr, tbl[i].exp_rd);
    end

    // Rising edge on bit 0 through synchroniser, capture and irq.
    wr(3'd2, 32'h01);
    in_port = 8'h01;
    tick();
    rd("edge_in_k", 3'd1, 32'h00);
    tick();
    rd("edge_in_k1", 3'd1, 32'h01);
    rd("edge_cap_k1", 3'd3, 32'h00);
    tick();
    rd("edge_cap_k2", 3'd3, 32'h01);
    check("edge_irq_k2", {31'h0, irq}, 32'h0);
    tick();
    check("edge_irq_k3", {31'h0, irq}, 32'h1);
    wr(3'd3, 32'h01);
    rd("w1c_cap", 3'd3, 32'h00);
    tick();
    check("w1c_irq", {31'h0, irq}, 32'h0);

    // Edge arriving in the same cycle as its W1C: set wins.
    in_port = 8'h09;
    tick(); tick();
    wr(3'd3, 32'h08);
    rd("race_cap", 3'd3, 32'h08);
    wr(3'd3, 32'hFF);
    rd("race_clr", 3'd3, 32'h00);

    // Single-cycle pulse on bit 1 with mask off, then unmask.
    wr(3'd2, 32'h00);
    in_port = 8'h0B;
    tick();
    in_port = 8'h09;
    tick(); tick(); tick(); tick();
    rd("pulse_cap", 3'd3, 32'h02);
    check("pulse_irq_masked", {31'h0, irq}, 32'h0);
    wr(3'd2, 32'h02);
    check("pulse_irq_wr_edge", {31'h0, irq}, 32'h0);
    tick();
    check("pulse_irq_unmasked", {31'h0, irq}, 32'h1);

    // Input already high across reset gives one capture three cycles later.
    in_port = 8'h01;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick(); tick();
    rd("rstexit_cap_2", 3'd3, 32'h00);
    tick();
    rd("rstexit_cap_3", 3'd3, 32'h01);

    // Randomized run against the model.
    for (int n = 0; n < 1500; n++) begin
      reset_n    = ($urandom_range(0, 99) != 0);
      chipselect = $urandom_range(0, 1);
      write_n    = $urandom_range(0, 2) == 0 ? 1'b0 : 1'b1;
      address    = 3'($urandom_range(0, 7));
      writedata  = $urandom;
      if ($urandom_range(0, 3) == 0) in_port = in_port ^ (8'(1) << $urandom_range(0, 7));
      tick();
      idle();
      check("rnd_out_port", {24'h0, out_port}, {24'h0, m_out});
      check("rnd_irq", {31'h0, irq}, {31'h0, m_irq});
      address = 3'($urandom_range(0, 7));
      #1;
      check($sformatf("rnd_rd_a%0d", address), readdata, rd_exp(address));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
